// File: rtl/regdump_streamer.sv
// Register-file snapshot unit: captures REGS_FLAT on a trigger and streams it
// out as a framed, checksummed byte stream (A5, count, data, sum) over valid/ready.
module regdump_streamer #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned RLEN   = 32,
    parameter int unsigned PERIOD = 0
) (
    input  logic                    XCLK,
    input  logic                    XRES,
    input  logic [NREGS*RLEN-1:0]   REGS_FLAT,
    input  logic                    TRIG,
    output logic [7:0]              DOUT,
    output logic                    DVALID,
    input  logic                    DREADY,
    output logic                    BUSY,
    output logic [7:0]              DROP
);

    localparam int unsigned FLATW    = NREGS * RLEN;
    localparam int unsigned NBYTES   = FLATW / 8;
    localparam int unsigned IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    localparam logic [7:0]  HDR_BYTE = 8'hA5;
    localparam logic [7:0]  CNT_BYTE = 8'(NREGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CNT,
        ST_DATA,
        ST_SUM
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [FLATW-1:0] snap;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_n;
    logic [7:0]      sum;
    logic [7:0]      sum_n;
    logic [7:0]      dout_n;
    logic            auto_pulse;
    logic            trig_eff;
    logic            xfer;
    logic            capture;
    logic            drop_evt;

    // Free-running auto-trigger counter, present only when PERIOD is non-zero
    if (PERIOD != 0) begin : g_auto
        logic [PW-1:0] pcnt;

        // Pulse on the last count of each period
        always_comb auto_pulse = (pcnt == PW'(PERIOD - 1));

        // Period counter wraps after PERIOD cycles, runs in every state
        always_ff @(posedge XCLK or posedge XRES) begin
            if (XRES) begin
                pcnt <= '0;
            end else if (auto_pulse) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end else begin : g_noauto
        // Auto-trigger disabled
        always_comb auto_pulse = 1'b0;
    end

    // Combine trigger sources; a simultaneous TRIG and auto pulse is one event
    always_comb begin
        trig_eff = TRIG | auto_pulse;
        xfer     = DVALID & DREADY;
        drop_evt = trig_eff & (state != ST_IDLE);
    end

    // Next-state, byte index, checksum and next output byte
    always_comb begin
        state_n = state;
        idx_n   = idx;
        sum_n   = sum;
        capture = 1'b0;
        dout_n  = 8'h00;

        unique case (state)
            ST_IDLE: begin
                if (trig_eff) begin
                    capture = 1'b1;
                    state_n = ST_HDR;
                    idx_n   = '0;
                    sum_n   = 8'h00;
                end
            end
            ST_HDR: begin
                if (xfer) state_n = ST_CNT;
            end
            ST_CNT: begin
                if (xfer) begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                    sum_n   = sum + CNT_BYTE;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    sum_n = sum + DOUT;
                    if (idx == LAST_IDX) begin
                        state_n = ST_SUM;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            ST_SUM: begin
                if (xfer) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        unique case (state_n)
            ST_HDR:  dout_n = HDR_BYTE;
            ST_CNT:  dout_n = CNT_BYTE;
            ST_DATA: dout_n = snap[{idx_n, 3'b000} +: 8];
            ST_SUM:  dout_n = sum_n;
            default: dout_n = 8'h00;
        endcase
    end

    // Control state and registered stream outputs
    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            state  <= ST_IDLE;
            idx    <= '0;
            sum    <= 8'h00;
            DOUT   <= 8'h00;
            DVALID <= 1'b0;
            BUSY   <= 1'b0;
            DROP   <= 8'h00;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            sum    <= sum_n;
            DOUT   <= dout_n;
            DVALID <= (state_n != ST_IDLE);
            BUSY   <= (state_n != ST_IDLE);
            if (drop_evt && (DROP != 8'hFF)) begin
                DROP <= DROP + 8'h01;
            end
        end
    end

    // Snapshot datapath; only read after a capture, so it carries no reset
    always_ff @(posedge XCLK) begin
        if (capture) begin
            snap <= REGS_FLAT;
        end
    end

endmodule
